// File: rtl/axi_read_slave.sv
// AXI4 read-only slave over a preloadable 32-bit word memory; FIXED/INCR/WRAP bursts, SLVERR/DECERR per beat.
// Latency: first R beat one cycle after AR handshake; one beat per cycle while RREADY is high.
// Backpressure: RREADY low freezes the current beat (data, resp, last, address); AR is refused until the burst ends.
module axi_read_slave #(
  parameter int          ADDR_W    = 8,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic              G_clk,
  input  logic              G_reset,
  input  logic [31:0]       ARADDR,
  input  logic [3:0]        ARLEN,
  input  logic [2:0]        ARSIZE,
  input  logic [1:0]        ARBURST,
  input  logic              ARVALID,
  output logic              ARREADY,
  output logic              RVALID,
  input  logic              RREADY,
  output logic [31:0]       RDATA,
  output logic [1:0]        RRESP,
  output logic              RLAST,
  input  logic              mem_we,
  input  logic [ADDR_W-1:0] mem_waddr,
  input  logic [31:0]       mem_wdata
);

  localparam int          DEPTH = 2 ** ADDR_W;
  // Byte span of the memory, kept 64 bits wide so large ADDR_W cannot overflow the range test.
  localparam logic [63:0] SPAN  = 64'd4 << ADDR_W;

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] DATA = 1'b1;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_WRAP  = 2'b10;
  localparam logic [1:0] BURST_RSVD  = 2'b11;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  logic [0:0]  state;
  logic [31:0] cur_addr;
  logic [3:0]  len_q;
  logic [2:0]  size_q;
  logic [1:0]  burst_q;
  logic [3:0]  beat_cnt;
  logic        slverr_q;

  logic [31:0] mem [DEPTH];

  logic        accept;
  logic        beat_done;
  logic        last_beat;
  logic        req_slverr;
  logic [31:0] size_bytes;
  logic [31:0] incr_addr;
  logic [31:0] container;
  logic [31:0] wrap_base;
  logic [31:0] wrap_addr;
  logic [31:0] next_addr;
  logic [31:0] offset;
  logic        in_range;
  logic [31:0] rd_word;

  assign ARREADY   = (state == IDLE);
  assign RVALID    = (state == DATA);
  assign accept    = ARVALID && ARREADY;
  assign beat_done = RVALID && RREADY;
  assign last_beat = (beat_cnt == len_q);

  // Protocol violations detectable from the request alone: oversize beats, reserved burst,
  // or a WRAP whose length is not a power of two.
  always_comb begin
    req_slverr = 1'b0;
    if (ARSIZE > 3'd2) begin
      req_slverr = 1'b1;
    end
    if (ARBURST == BURST_RSVD) begin
      req_slverr = 1'b1;
    end
    if ((ARBURST == BURST_WRAP) &&
        !((ARLEN == 4'd1) || (ARLEN == 4'd3) || (ARLEN == 4'd7) || (ARLEN == 4'd15))) begin
      req_slverr = 1'b1;
    end
  end

  // Next beat address. The WRAP container is a power of two for every legal WRAP, so the
  // mask alignment is exact; for illegal WRAPs the address is irrelevant (data is forced to 0).
  always_comb begin
    size_bytes = 32'd1 << size_q;
    incr_addr  = cur_addr + size_bytes;
    container  = size_bytes * ({28'd0, len_q} + 32'd1);
    wrap_base  = cur_addr & ~(container - 32'd1);
    wrap_addr  = (incr_addr == (wrap_base + container)) ? wrap_base : incr_addr;
    case (burst_q)
      BURST_FIXED: next_addr = cur_addr;
      BURST_WRAP:  next_addr = wrap_addr;
      default:     next_addr = incr_addr;
    endcase
  end

  // Decode: the beat hits memory only when the byte address falls inside [BASE, BASE+SPAN).
  always_comb begin
    offset   = cur_addr - BASE_ADDR;
    in_range = (cur_addr >= BASE_ADDR) && ({32'd0, offset} < SPAN);
    rd_word  = mem[offset[ADDR_W+1:2]];
  end

  // R channel outputs: all zero outside DATA; SLVERR outranks DECERR, errors return zero data.
  always_comb begin
    RDATA = 32'd0;
    RRESP = RESP_OKAY;
    RLAST = 1'b0;
    if (RVALID) begin
      RLAST = last_beat;
      if (slverr_q) begin
        RRESP = RESP_SLVERR;
      end else if (!in_range) begin
        RRESP = RESP_DECERR;
      end else begin
        RDATA = rd_word;
      end
    end
  end

  // Burst control: capture the request in IDLE, step address/counter on each accepted beat.
  always_ff @(posedge G_clk) begin
    if (!G_reset) begin
      state    <= IDLE;
      cur_addr <= 32'd0;
      len_q    <= 4'd0;
      size_q   <= 3'd0;
      burst_q  <= 2'b00;
      beat_cnt <= 4'd0;
      slverr_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            cur_addr <= ARADDR;
            len_q    <= ARLEN;
            size_q   <= ARSIZE;
            burst_q  <= ARBURST;
            beat_cnt <= 4'd0;
            slverr_q <= req_slverr;
            state    <= DATA;
          end
        end
        default: begin
          if (beat_done) begin
            if (last_beat) begin
              state <= IDLE;
            end else begin
              beat_cnt <= beat_cnt + 4'd1;
              cur_addr <= next_addr;
            end
          end
        end
      endcase
    end
  end

  // Preload port: writes land at the edge, so a read in the same cycle still sees the old word.
  // Memory is deliberately not reset.
  always_ff @(posedge G_clk) begin
    if (mem_we) begin
      mem[mem_waddr] <= mem_wdata;
    end
  end

endmodule

// File: tb/tb_axi_read_slave.sv
// Bench for axi_read_slave: directed bursts plus randomized bursts scored against a burst-level model.
// Latency: checks first beat one cycle after AR, and ARREADY one cycle after the last beat.
// Backpressure: drives RREADY always-on, alternating and random; every held cycle is re-checked.
module tb_axi_read_slave;

  localparam int          ADDR_W = 8;
  localparam int          DEPTH  = 256;
  localparam logic [31:0] BASE   = 32'h0000_0000;

  logic              G_clk = 1'b0;
  logic              G_reset;
  logic [31:0]       ARADDR;
  logic [3:0]        ARLEN;
  logic [2:0]        ARSIZE;
  logic [1:0]        ARBURST;
  logic              ARVALID;
  logic              ARREADY;
  logic              RVALID;
  logic              RREADY;
  logic [31:0]       RDATA;
  logic [1:0]        RRESP;
  logic              RLAST;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [31:0]       mem_wdata;

  int compared   = 0;
  int mismatched = 0;

  logic [31:0] shadow [DEPTH];

  axi_read_slave #(.ADDR_W(ADDR_W), .BASE_ADDR(BASE)) dut (
    .G_clk(G_clk), .G_reset(G_reset),
    .ARADDR(ARADDR), .ARLEN(ARLEN), .ARSIZE(ARSIZE), .ARBURST(ARBURST),
    .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RVALID(RVALID), .RREADY(RREADY), .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST),
    .mem_we(mem_we), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata)
  );

  always #5 G_clk = ~G_clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Address of beat i, straight from the burst definitions (WRAP as modular offset within the container).
  function automatic logic [31:0] beat_addr(input logic [31:0] a0, input logic [3:0] len,
                                            input logic [2:0] size, input logic [1:0] burst, input int i);
    logic [31:0] sz, cont, base;
    sz = 32'd1 << size;
    case (burst)
      2'b00: return a0;
      2'b10: begin
        cont = sz * (32'(len) + 32'd1);
        base = a0 - (a0 % cont);
        return base + (((a0 - base) + 32'(i) * sz) % cont);
      end
      default: return a0 + 32'(i) * sz;
    endcase
  endfunction

  // Expected {RDATA, RRESP, RLAST} for beat i.
  function automatic logic [34:0] exp_beat(input logic [31:0] a0, input logic [3:0] len,
                                           input logic [2:0] size, input logic [1:0] burst, input int i);
    logic [31:0] a;
    logic        slv;
    logic        last;
    slv  = (size > 3'd2) || (burst == 2'b11) ||
           ((burst == 2'b10) && !(len == 4'd1 || len == 4'd3 || len == 4'd7 || len == 4'd15));
    last = (i == int'(len));
    a    = beat_addr(a0, len, size, burst, i);
    if (slv) return {32'd0, 2'b10, last};
    if (a < BASE || (a - BASE) >= 32'(4 * DEPTH)) return {32'd0, 2'b11, last};
    return {shadow[int'((a - BASE) >> 2)], 2'b00, last};
  endfunction

  task automatic write_word(input int idx, input logic [31:0] d);
    @(negedge G_clk);
    mem_we    = 1'b1;
    mem_waddr = ADDR_W'(idx);
    mem_wdata = d;
    @(negedge G_clk);
    mem_we    = 1'b0;
    shadow[idx] = d;
  endtask

  // mode 0: RREADY always 1; mode 1: alternating 0/1; mode 2: random.
  task automatic run_burst(input logic [31:0] a0, input logic [3:0] len, input logic [2:0] size,
                           input logic [1:0] burst, input int mode, input string name);
    int          beat;
    int          cyc;
    logic        rdy;
    logic [36:0] got;
    logic [36:0] exp;
    beat = 0;
    cyc  = 0;
    @(negedge G_clk);
    ARADDR  = a0;
    ARLEN   = len;
    ARSIZE  = size;
    ARBURST = burst;
    ARVALID = 1'b1;
    compared++;
    if (ARREADY !== 1'b1) begin
      mismatched++;
      $display("FAIL %s arready: got %b want 1", name, ARREADY);
    end
    @(negedge G_clk);
    ARVALID = 1'b0;
    ARADDR  = $urandom;
    ARLEN   = 4'($urandom);
    while (beat <= int'(len) && cyc < 200) begin
      case (mode)
        0:       rdy = 1'b1;
        1:       rdy = (cyc % 2) == 1;
        default: rdy = 1'($urandom_range(0, 1));
      endcase
      RREADY = rdy;
      exp = {1'b1, 1'b0, exp_beat(a0, len, size, burst, beat)};
      got = {RVALID, ARREADY, RDATA, RRESP, RLAST};
      compared++;
      if (got !== exp) begin
        mismatched++;
        $display("FAIL %s beat %0d: got v=%b ar=%b d=%h r=%b l=%b want v=%b ar=%b d=%h r=%b l=%b",
                 name, beat, got[36], got[35], got[34:3], got[2:1], got[0],
                 exp[36], exp[35], exp[34:3], exp[2:1], exp[0]);
      end
      if (RVALID !== 1'b1) break;
      if (rdy) beat++;
      @(negedge G_clk);
      cyc++;
    end
    RREADY = 1'b0;
    compared++;
    if (beat != int'(len) + 1) begin
      mismatched++;
      $display("FAIL %s beat count: got %0d want %0d", name, beat, int'(len) + 1);
    end
    compared++;
    if ({ARREADY, RVALID, RLAST, RRESP, RDATA} !== {1'b1, 1'b0, 1'b0, 2'b00, 32'd0}) begin
      mismatched++;
      $display("FAIL %s idle after burst: got ar=%b v=%b l=%b r=%b d=%h want ar=1 v=0 l=0 r=00 d=0",
               name, ARREADY, RVALID, RLAST, RRESP, RDATA);
    end
  endtask

  task automatic test_reset();
    G_reset = 1'b0;
    repeat (2) @(negedge G_clk);
    compared++;
    if ({ARREADY, RVALID, RLAST, RRESP, RDATA} !== {1'b1, 1'b0, 1'b0, 2'b00, 32'd0}) begin
      mismatched++;
      $display("FAIL reset outputs: got ar=%b v=%b l=%b r=%b d=%h want ar=1 v=0 l=0 r=00 d=0",
               ARREADY, RVALID, RLAST, RRESP, RDATA);
    end
    G_reset = 1'b1;
  endtask

  task automatic test_preload();
    for (int i = 0; i < DEPTH; i++) write_word(i, $urandom);
    for (int i = 0; i < 4; i++) write_word(i, 32'hA0A0_0000 + 32'(i));
    write_word(4, 32'hC0DE_0004);
  endtask

  task automatic test_incr();
    run_burst(32'h0, 4'd3, 3'd2, 2'b01, 0, "incr");
  endtask

  task automatic test_wrap();
    run_burst(32'h8, 4'd3, 3'd2, 2'b10, 0, "wrap");
  endtask

  task automatic test_backpressure();
    run_burst(32'h20, 4'd7, 3'd2, 2'b01, 1, "backpressure");
  endtask

  task automatic test_errors();
    run_burst(32'h0, 4'd3, 3'd3, 2'b01, 0, "slverr size3");
    run_burst(32'(4 * (DEPTH - 1)), 4'd1, 3'd2, 2'b01, 0, "decerr end");
    run_burst(32'h0, 4'd2, 3'd2, 2'b10, 2, "slverr wrap len3");
    run_burst(32'h40, 4'd1, 3'd2, 2'b11, 0, "slverr reserved");
  endtask

  task automatic test_fixed();
    run_burst(32'h10, 4'd2, 3'd2, 2'b00, 0, "fixed");
  endtask

  // Preload write while a beat is held: old word before the edge, new word after it.
  task automatic test_write_during_burst();
    @(negedge G_clk);
    ARADDR = 32'h10; ARLEN = 4'd0; ARSIZE = 3'd2; ARBURST = 2'b00; ARVALID = 1'b1;
    @(negedge G_clk);
    ARVALID   = 1'b0;
    RREADY    = 1'b0;
    mem_we    = 1'b1;
    mem_waddr = ADDR_W'(4);
    mem_wdata = 32'h5EED_F00D;
    compared++;
    if (RDATA !== shadow[4]) begin
      mismatched++;
      $display("FAIL memwrite old: got %h want %h", RDATA, shadow[4]);
    end
    @(negedge G_clk);
    mem_we    = 1'b0;
    shadow[4] = 32'h5EED_F00D;
    compared++;
    if (RDATA !== shadow[4]) begin
      mismatched++;
      $display("FAIL memwrite new: got %h want %h", RDATA, shadow[4]);
    end
    RREADY = 1'b1;
    @(negedge G_clk);
    RREADY = 1'b0;
  endtask

  task automatic test_reset_mid_burst();
    @(negedge G_clk);
    ARADDR = 32'h0; ARLEN = 4'd3; ARSIZE = 3'd2; ARBURST = 2'b01; ARVALID = 1'b1;
    @(negedge G_clk);
    ARVALID = 1'b0;
    RREADY  = 1'b1;
    @(negedge G_clk);
    compared++;
    if (RDATA !== shadow[1] || RVALID !== 1'b1) begin
      mismatched++;
      $display("FAIL rst_mid beat2: got v=%b d=%h want v=1 d=%h", RVALID, RDATA, shadow[1]);
    end
    G_reset = 1'b0;
    @(negedge G_clk);
    G_reset = 1'b1;
    compared++;
    if ({ARREADY, RVALID, RLAST, RRESP, RDATA} !== {1'b1, 1'b0, 1'b0, 2'b00, 32'd0}) begin
      mismatched++;
      $display("FAIL rst_mid after: got ar=%b v=%b l=%b r=%b d=%h want ar=1 v=0 l=0 r=00 d=0",
               ARREADY, RVALID, RLAST, RRESP, RDATA);
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge G_clk);
      compared++;
      if (RVALID !== 1'b0) begin
        mismatched++;
        $display("FAIL rst_mid stray beat: got v=%b want 0", RVALID);
      end
    end
    RREADY = 1'b0;
    run_burst(32'h40, 4'd3, 3'd2, 2'b01, 0, "after reset");
  endtask

  task automatic test_random();
    logic [31:0] a;
    logic [3:0]  len;
    logic [2:0]  size;
    logic [1:0]  burst;
    int          kind;
    for (int n = 0; n < 40; n++) begin
      kind  = $urandom_range(0, 7);
      if (kind < 6)       a = 32'($urandom_range(0, 4 * DEPTH - 1));
      else if (kind == 6) a = 32'($urandom_range(4 * DEPTH - 64, 4 * DEPTH + 64));
      else                a = 32'hFFFF_FF00 + 32'($urandom_range(0, 255));
      size  = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(3, 7)) : 3'($urandom_range(0, 2));
      burst = 2'($urandom_range(0, 3));
      len   = 4'($urandom_range(0, 15));
      if (burst == 2'b10 && $urandom_range(0, 3) != 0) begin
        case ($urandom_range(0, 3))
          0:       len = 4'd1;
          1:       len = 4'd3;
          2:       len = 4'd7;
          default: len = 4'd15;
        endcase
      end
      a = a & ~((32'd1 << size) - 32'd1);
      run_burst(a, len, size, burst, 2, "random");
    end
  endtask

  initial begin
    G_reset   = 1'b0;
    ARADDR    = 32'd0;
    ARLEN     = 4'd0;
    ARSIZE    = 3'd0;
    ARBURST   = 2'b00;
    ARVALID   = 1'b0;
    RREADY    = 1'b0;
    mem_we    = 1'b0;
    mem_waddr = '0;
    mem_wdata = 32'd0;
    test_reset();
    test_preload();
    test_incr();
    test_wrap();
    test_backpressure();
    test_errors();
    test_fixed();
    test_write_during_burst();
    test_reset_mid_burst();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/axi_read_slave.md
AXI_READ_SLAVE -- requirements
Module: axi_read_slave

Interface
REQ-001 SHALL have parameter ADDR_W, default 8; memory word-index width, so depth = 2**ADDR_W 32-bit words.
REQ-002 SHALL have parameter BASE_ADDR, default 32'h0000_0000; byte address of memory word 0.
REQ-003 SHALL have port G_clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port G_reset  input  1  synchronous, active-low reset.
REQ-005 SHALL have port ARADDR  input  32  read burst start byte address.
REQ-006 SHALL have port ARLEN  input  4  burst length minus one (1..16 beats).
REQ-007 SHALL have port ARSIZE  input  3  bytes per beat = 1<<ARSIZE.
REQ-008 SHALL have port ARBURST  input  2  burst type: 00 FIXED, 01 INCR, 10 WRAP, 11 reserved.
REQ-009 SHALL have port ARVALID  input  1  address valid.
REQ-010 SHALL have port ARREADY  output  1  address accepted when high with ARVALID.
REQ-011 SHALL have port RVALID  output  1  read beat valid.
REQ-012 SHALL have port RREADY  input  1  master accepts beat.
REQ-013 SHALL have port RDATA  output  32  beat data.
REQ-014 SHALL have port RRESP  output  2  beat response: 00 OKAY, 10 SLVERR, 11 DECERR.
REQ-015 SHALL have port RLAST  output  1  final beat of burst.
REQ-016 SHALL have port mem_we  input  1  preload write enable.
REQ-017 SHALL have port mem_waddr  input  ADDR_W  preload word index.
REQ-018 SHALL have port mem_wdata  input  32  preload data.

Function
REQ-019 SHALL implement FSM with states IDLE and DATA; ARREADY = (state==IDLE), RVALID = (state==DATA).
REQ-020 SHALL, in IDLE on ARVALID&ARREADY, register ARADDR, ARLEN, ARSIZE, ARBURST, clear beat counter, and enter DATA; first RVALID in the following cycle (1-cycle latency).
REQ-021 SHALL hold RDATA, RRESP, RLAST, and the current address stable while RVALID=1 and RREADY=0.
REQ-022 SHALL drive RDATA = mem[(cur_addr - BASE_ADDR) >> 2] combinationally from the current address register, always the full 32-bit word containing cur_addr, including for narrow sizes.
REQ-023 SHALL drive RLAST = 1 exactly when beat counter == registered ARLEN.
REQ-024 SHALL, on RVALID&RREADY with RLAST=0, increment the beat counter and advance the address; with RLAST=1, return to IDLE so ARREADY=1 in the next cycle. No new address is accepted before that cycle.
REQ-025 SHALL advance the address as follows: FIXED keeps it unchanged; INCR and reserved add 1<<size modulo 2**32.
REQ-026 SHALL advance the address for WRAP as follows: container = (1<<size)*(len+1) and base = addr aligned down to container; next = base when addr + (1<<size) == base + container, else addr + (1<<size).
REQ-027 SHALL return RRESP=SLVERR with RDATA=0 for every beat of a burst whose ARSIZE>2, ARBURST=11, or WRAP with ARLEN not in {1,3,7,15}; beat count and RLAST still follow ARLEN.
REQ-028 SHALL return RRESP=DECERR with RDATA=0 for any beat whose cur_addr < BASE_ADDR or cur_addr - BASE_ADDR >= 4*2**ADDR_W; the check is per beat, so an INCR burst may go OKAY then DECERR.
REQ-029 SHALL give SLVERR priority over DECERR, and return OKAY otherwise.
REQ-030 SHALL drive RDATA=0, RRESP=00, RLAST=0 whenever RVALID=0.
REQ-031 SHALL write mem[mem_waddr] <= mem_wdata on any clock with mem_we=1, in any state. A same-cycle read of that word returns the old value, and the new value appears from the next cycle.

Reset
REQ-032 SHALL, on a clock edge with G_reset=0, set state IDLE and clear all burst registers; outputs after that edge: ARREADY=1, RVALID=0, RLAST=0, RRESP=00, RDATA=0.
REQ-033 SHALL abort a burst when reset occurs mid-burst, with no further beats after release; memory contents are not reset.

Verification
REQ-034 SHALL cover INCR read: preload words 0..3 = A0..A3, ARADDR=0, ARLEN=3, ARSIZE=2 -> 4 beats A0..A3, RLAST on beat 4 only, RRESP=00.
REQ-035 SHALL cover WRAP read: ARADDR=0x08, ARLEN=3, ARSIZE=2, ARBURST=10 -> words 2,3,0,1.
REQ-036 SHALL cover backpressure: RREADY toggled 0/1 each cycle during an 8-beat INCR -> each beat held stable until accepted, 8 beats total, no loss or duplication.
REQ-037 SHALL cover errors: ARSIZE=3 -> all beats SLVERR with RDATA=0. An INCR starting at last word, ARLEN=1 -> beat1 OKAY, beat2 DECERR.
REQ-038 SHALL cover FIXED read: ARADDR=0x10, ARLEN=2 -> word 4 returned 3 times.
REQ-039 SHALL cover reset mid-burst: G_reset=0 for one cycle on beat 2 of 4 -> RVALID=0 and ARREADY=1 after the edge, and a new burst then completes correctly.
